// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared types and helpers for the multicycle ARM datapath.
//   state_t   - main-control FSM states
//   cond_t    - ARM condition field encodings
//   CMD_*     - supported data-processing opcodes
//   SH_*      - shift types for the register operand
//   cond_pass - evaluate a condition field against {N,Z,C,V}
package arm_mc_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, HALT
   } state_t;

   typedef enum logic [3:0] {
      COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
      COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
   } cond_t;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   // nzcv packing: [3]=N [2]=Z [1]=C [0]=V
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond_t'(cond))
         COND_EQ: cond_pass = z;
         COND_NE: cond_pass = !z;
         COND_CS: cond_pass = c;
         COND_CC: cond_pass = !c;
         COND_MI: cond_pass = n;
         COND_PL: cond_pass = !n;
         COND_VS: cond_pass = v;
         COND_VC: cond_pass = !v;
         COND_HI: cond_pass = c && !z;
         COND_LS: cond_pass = !c || z;
         COND_GE: cond_pass = (n == v);
         COND_LT: cond_pass = (n != v);
         COND_GT: cond_pass = !z && (n == v);
         COND_LE: cond_pass = z || (n != v);
         COND_AL: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/arm_mc_shifter.sv
// arm_mc_shifter: combinational barrel shifter for the second ALU operand.
//   val_i  - 32-bit value to shift
//   type_i - LSL/LSR/ASR/ROR
//   amt_i  - shift amount; zero leaves the value untouched for every type
//   res_o  - shifted result
module arm_mc_shifter
   import arm_mc_pkg::*;
(
   input  logic [31:0] val_i,
   input  logic [1:0]  type_i,
   input  logic [4:0]  amt_i,
   output logic [31:0] res_o
);
   always_comb begin
      res_o = val_i;
      if (amt_i != 5'd0) begin
         case (type_i)
            SH_LSL:  res_o = val_i << amt_i;
            SH_LSR:  res_o = val_i >> amt_i;
            SH_ASR:  res_o = $unsigned($signed(val_i) >>> amt_i);
            default: res_o = (val_i >> amt_i) | (val_i << (6'd32 - {1'b0, amt_i}));
         endcase
      end
   end
endmodule

// File: rtl/arm_multicycle_datapath.sv
// arm_multicycle_datapath: multicycle ARM-subset core with one shared
// req/ready memory port for instruction fetch and data access.
//   clk, reset (async, active low)
//   mem_req/mem_we/mem_addr/mem_wdata -> memory; mem_rdata/mem_ready <- memory
//   PC, Instr, halted, cycle_cnt, instret_cnt -> status
//
// state  | meaning
// FETCH  | request instruction at PC; on ready latch it, PC += 4
// DECODE | read operands, test condition, dispatch on op
// MEMADR | ALUOut = Rn +/- imm12
// MEMRD  | load request at ALUOut
// MEMWB  | write loaded data to Rd (or PC)
// MEMWR  | store request at ALUOut with R[Rd]
// EXEC   | data-processing ALU op, optional flag update
// ALUWB  | write ALUOut to Rd (or PC)
// BRANCH | PC += 4 + offset, optional link into R14
// HALT   | illegal instruction, frozen until reset
module arm_multicycle_datapath
   import arm_mc_pkg::*;
#(
   parameter int          ADDR_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          CNT_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       PC,
   output logic [31:0]       Instr,
   output logic              halted,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  instret_cnt
);
   state_t           state_q;
   logic [31:0]      pc_q, instr_q, a_q, b_q, alu_q, data_q;
   logic [31:0]      rf_q [15];
   logic [3:0]       nzcv_q;
   logic [CNT_W-1:0] cyc_q, ret_q;

   logic [3:0]  cond, cmd, rn, rd, rm, rot, rb_idx;
   logic [1:0]  op, sh;
   logic [4:0]  shamt;
   logic [7:0]  imm8;
   logic        imm_i, s_bit, u_bit, l_mem, l_br;
   logic [31:0] rn_val, rb_val, srcb, sh_val, br_off, mem_off;
   logic [1:0]  sh_type;
   logic [4:0]  sh_amt;
   logic [32:0] sum_d;
   logic [31:0] alu_d;
   logic        c_d, v_d, alu_ok;

   assign cond    = instr_q[31:28];
   assign op      = instr_q[27:26];
   assign imm_i   = instr_q[25];
   assign cmd     = instr_q[24:21];
   assign s_bit   = instr_q[20];
   assign rn      = instr_q[19:16];
   assign rd      = instr_q[15:12];
   assign rot     = instr_q[11:8];
   assign imm8    = instr_q[7:0];
   assign shamt   = instr_q[11:7];
   assign sh      = instr_q[6:5];
   assign rm      = instr_q[3:0];
   assign u_bit   = instr_q[23];
   assign l_mem   = instr_q[20];
   assign l_br    = instr_q[24];
   assign br_off  = {{6{instr_q[23]}}, instr_q[23:0], 2'b00};
   assign mem_off = {20'h0, instr_q[11:0]};

   // pc_q already points past the fetched word here, so R15 reads see fetch+8
   always_comb begin
      rb_idx = (op == 2'b01) ? rd : rm;
      rn_val = (rn == 4'd15) ? pc_q + 32'd4 : rf_q[rn];
      rb_val = (rb_idx == 4'd15) ? pc_q + 32'd4 : rf_q[rb_idx];
   end

   // immediate operand reuses the shifter as a rotate by 2*rot
   assign sh_val  = imm_i ? {24'h0, imm8} : b_q;
   assign sh_type = imm_i ? SH_ROR : sh;
   assign sh_amt  = imm_i ? {rot, 1'b0} : shamt;

   arm_mc_shifter u_shifter (
      .val_i  (sh_val),
      .type_i (sh_type),
      .amt_i  (sh_amt),
      .res_o  (srcb)
   );

   always_comb begin
      sum_d  = 33'h0;
      alu_d  = 32'h0;
      c_d    = nzcv_q[1];
      v_d    = nzcv_q[0];
      alu_ok = 1'b1;
      case (cmd)
         CMD_ADD: begin
            sum_d = {1'b0, a_q} + {1'b0, srcb};
            alu_d = sum_d[31:0];
            c_d   = sum_d[32];
            v_d   = (a_q[31] == srcb[31]) && (alu_d[31] != a_q[31]);
         end
         CMD_SUB: begin
            sum_d = {1'b0, a_q} + {1'b0, ~srcb} + 33'd1;
            alu_d = sum_d[31:0];
            c_d   = sum_d[32];
            v_d   = (a_q[31] != srcb[31]) && (alu_d[31] != a_q[31]);
         end
         CMD_AND: alu_d = a_q & srcb;
         CMD_ORR: alu_d = a_q | srcb;
         default: alu_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         a_q     <= 32'h0;
         b_q     <= 32'h0;
         alu_q   <= 32'h0;
         data_q  <= 32'h0;
         nzcv_q  <= 4'h0;
         cyc_q   <= '0;
         ret_q   <= '0;
         for (int i = 0; i < 15; i++) rf_q[i] <= 32'h0;
      end else begin
         if (state_q != HALT) cyc_q <= cyc_q + CNT_W'(1);
         case (state_q)
            FETCH: if (mem_ready) begin
               instr_q <= mem_rdata;
               pc_q    <= pc_q + 32'd4;
               state_q <= DECODE;
            end
            DECODE: begin
               a_q <= rn_val;
               b_q <= rb_val;
               if (cond == 4'b1111) begin
                  state_q <= HALT;
               end else if (!cond_pass(cond, nzcv_q)) begin
                  ret_q   <= ret_q + CNT_W'(1);
                  state_q <= FETCH;
               end else begin
                  case (op)
                     2'b00:   state_q <= EXEC;
                     2'b01:   state_q <= MEMADR;
                     2'b10:   state_q <= BRANCH;
                     default: state_q <= HALT;
                  endcase
               end
            end
            EXEC: begin
               if (alu_ok) begin
                  alu_q <= alu_d;
                  if (s_bit) nzcv_q <= {alu_d[31], (alu_d == 32'h0), c_d, v_d};
                  state_q <= ALUWB;
               end else begin
                  state_q <= HALT;
               end
            end
            ALUWB: begin
               if (rd == 4'd15) pc_q <= alu_q;
               else rf_q[rd] <= alu_q;
               ret_q   <= ret_q + CNT_W'(1);
               state_q <= FETCH;
            end
            MEMADR: begin
               alu_q   <= u_bit ? a_q + mem_off : a_q - mem_off;
               state_q <= l_mem ? MEMRD : MEMWR;
            end
            MEMRD: if (mem_ready) begin
               data_q  <= mem_rdata;
               state_q <= MEMWB;
            end
            MEMWB: begin
               if (rd == 4'd15) pc_q <= data_q;
               else rf_q[rd] <= data_q;
               ret_q   <= ret_q + CNT_W'(1);
               state_q <= FETCH;
            end
            MEMWR: if (mem_ready) begin
               ret_q   <= ret_q + CNT_W'(1);
               state_q <= FETCH;
            end
            BRANCH: begin
               pc_q <= pc_q + 32'd4 + br_off;
               if (l_br) rf_q[14] <= pc_q;
               ret_q   <= ret_q + CNT_W'(1);
               state_q <= FETCH;
            end
            default: state_q <= HALT;
         endcase
      end
   end

   // gating with reset drops a pending request the moment reset asserts
   assign mem_req     = reset && (state_q == FETCH || state_q == MEMRD || state_q == MEMWR);
   assign mem_we      = mem_req && (state_q == MEMWR);
   assign mem_addr    = ADDR_W'((state_q == FETCH) ? pc_q : alu_q);
   assign mem_wdata   = b_q;
   assign PC          = pc_q;
   assign Instr       = instr_q;
   assign halted      = (state_q == HALT);
   assign cycle_cnt   = cyc_q;
   assign instret_cnt = ret_q;

endmodule

// File: tb/tb_arm_multicycle_datapath.sv
module tb_arm_multicycle_datapath;
   logic        clk, reset;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, PC, Instr;
   logic        halted;
   logic [31:0] cycle_cnt, instret_cnt;

   arm_multicycle_datapath dut (
      .clk(clk), .reset(reset),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .PC(PC), .Instr(Instr), .halted(halted),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [3:0] C_AND = 4'b0000, C_SUB = 4'b0010, C_ADD = 4'b0100,
                          C_ORR = 4'b1100, C_EOR = 4'b0001;

   // memory model: ready after lat wait cycles
   logic [31:0] mem [64];
   int unsigned lat, wait_cnt;
   logic        hold_ready;
   int          st_total, st_good, halt_req;

   assign mem_ready = mem_req && !hold_ready && (wait_cnt >= lat);
   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= 0;
      end else if (mem_req && mem_ready) begin
         wait_cnt <= 0;
         if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
      end else if (mem_req) begin
         wait_cnt <= wait_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (reset && mem_req && mem_we) begin
         st_total++;
         if (mem_addr == 32'h8 && mem_wdata == 32'h5) st_good++;
      end
      if (halted && mem_req) halt_req++;
   end

   int n_checks, n_pass;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] dp(input logic [3:0] cmd, input logic i, input logic s,
                                      input logic [3:0] rn, input logic [3:0] rd,
                                      input logic [11:0] op2);
      return {4'hE, 2'b00, i, cmd, s, rn, rd, op2};
   endfunction

   function automatic logic [11:0] rsh(input logic [4:0] amt, input logic [1:0] typ,
                                       input logic [3:0] rm);
      return {amt, typ, 1'b0, rm};
   endfunction

   task automatic wait_retire(input string name);
      logic [31:0] start;
      logic        ok;
      start = instret_cnt;
      ok    = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (instret_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_retire"}, 32'(ok), 32'd1);
   endtask

   task automatic wait_halt(input string name);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (halted) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_halt"}, 32'(ok), 32'd1);
   endtask

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] instr;
      int unsigned lat;
      int          ridx;
      logic [31:0] rexp;
      logic [31:0] pcexp;
   } vec_t;

   vec_t vecs [14];
   logic [31:0] cnt0, ret0;

   initial begin
      n_checks = 0; n_pass = 0;
      st_total = 0; st_good = 0; halt_req = 0;
      lat = 0; hold_ready = 1'b1; reset = 1'b0;

      vecs[0]  = '{"bl",      32'h10, 32'hEB000002,                           0, 14, 32'h14,       32'h20};
      vecs[1]  = '{"adds_r6", 32'h20, dp(C_ADD, 1, 1, 0, 6, 12'h001),         1, 6,  32'h1,        32'h24};
      vecs[2]  = '{"beq_nt",  32'h24, 32'h0A000001,                           0, 14, 32'h14,       32'h28};
      vecs[3]  = '{"imm_rot", 32'h28, dp(C_ADD, 1, 0, 0, 4, 12'h102),         0, 4,  32'h80000000, 32'h2C};
      vecs[4]  = '{"orr_asr", 32'h2C, dp(C_ORR, 0, 0, 0, 5, rsh(4, 2'b10, 4)), 2, 5,  32'hF8000000, 32'h30};
      vecs[5]  = '{"add_f",   32'h30, dp(C_ADD, 1, 0, 0, 7, 12'h00F),         0, 7,  32'h0000000F, 32'h34};
      vecs[6]  = '{"orr_ror", 32'h34, dp(C_ORR, 0, 0, 0, 8, rsh(4, 2'b11, 7)), 1, 8,  32'hF0000000, 32'h38};
      vecs[7]  = '{"lsr0",    32'h38, dp(C_ADD, 0, 0, 0, 9, rsh(0, 2'b01, 4)), 0, 9,  32'h80000000, 32'h3C};
      vecs[8]  = '{"add_lsl", 32'h3C, dp(C_ADD, 0, 0, 7, 10, rsh(4, 2'b00, 7)), 0, 10, 32'h000000FF, 32'h40};
      vecs[9]  = '{"sub_neg", 32'h40, dp(C_SUB, 0, 0, 0, 11, rsh(0, 2'b00, 7)), 2, 11, 32'hFFFFFFF1, 32'h44};
      vecs[10] = '{"and",     32'h44, dp(C_AND, 0, 0, 5, 12, rsh(0, 2'b00, 8)), 0, 12, 32'hF0000000, 32'h48};
      vecs[11] = '{"r15_rd",  32'h48, dp(C_ADD, 1, 0, 15, 13, 12'h000),       0, 13, 32'h50,       32'h4C};
      vecs[12] = '{"pc_wr",   32'h4C, dp(C_ADD, 1, 0, 0, 15, 12'h060),        0, 13, 32'h50,       32'h60};
      vecs[13] = '{"lsr31",   32'h60, dp(C_ADD, 0, 0, 0, 9, rsh(31, 2'b01, 4)), 0, 9, 32'h1,       32'h64};

      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0] = dp(C_ADD, 1, 0, 0, 1, 12'h005);   // ADD  R1,R0,#5
      mem[1] = dp(C_SUB, 1, 1, 1, 2, 12'h005);   // SUBS R2,R1,#5
      mem[2] = 32'hE5801008;                     // STR  R1,[R0,#8]
      mem[3] = 32'hE5903008;                     // LDR  R3,[R0,#8]
      for (int i = 0; i < 14; i++) mem[vecs[i].addr[7:2]] = vecs[i].instr;
      mem[25] = 32'hEC000000;                    // op=11 at 0x64

      // reset pulse in the middle of a stalled fetch
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("stall_req", 32'(mem_req), 32'd1);
      check("stall_cyc", cycle_cnt, 32'd3);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_pc", PC, 32'h0);
      check("rst_cyc", cycle_cnt, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      hold_ready = 1'b0;
      #1;
      check("post_req", 32'(mem_req), 32'd1);
      check("post_addr", mem_addr, 32'h0);
      check("post_cyc", cycle_cnt, 32'd0);

      // ADD then SUBS with zero-wait memory: 4 cycles each
      repeat (8) @(posedge clk);
      #1;
      check("instret2", instret_cnt, 32'd2);
      check("cyc8", cycle_cnt, 32'd8);
      check("r1", dut.rf_q[1], 32'h5);
      check("r2", dut.rf_q[2], 32'h0);
      check("nzcv", 32'(dut.nzcv_q), 32'h6);

      // store/load with three wait cycles
      lat = 3;
      wait_retire("str");
      check("str_stable", st_good, 32'd4);
      check("str_cycles", st_total, 32'd4);
      check("str_mem", mem[2], 32'h5);
      wait_retire("ldr");
      check("ldr_r3", dut.rf_q[3], 32'h5);
      check("ldr_nowr", st_total, 32'd4);

      for (int i = 0; i < 14; i++) begin
         lat = vecs[i].lat;
         wait_retire(vecs[i].name);
         check({vecs[i].name, "_pc"}, PC, vecs[i].pcexp);
         check({vecs[i].name, "_reg"}, dut.rf_q[vecs[i].ridx], vecs[i].rexp);
      end
      check("instret_tbl", instret_cnt, 32'd18);

      // op=11 halts; counter frozen, no requests
      lat = 0;
      wait_halt("op11");
      cnt0 = cycle_cnt;
      ret0 = instret_cnt;
      repeat (5) @(posedge clk);
      #1;
      check("halt_cyc", cycle_cnt, cnt0);
      check("halt_ret", instret_cnt, ret0);
      check("halt_req", 32'(mem_req), 32'd0);

      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_r5", dut.rf_q[5], 32'h0);
      check("rst_ret", instret_cnt, 32'd0);
      mem[0] = dp(C_EOR, 0, 0, 0, 1, 12'h000);   // EOR R1,R0,R0 unsupported
      @(negedge clk);
      reset = 1'b1;
      wait_halt("eor");
      repeat (3) @(posedge clk);
      #1;
      check("eor_cyc", cycle_cnt, 32'd3);
      check("eor_ret", instret_cnt, 32'd0);
      check("eor_pc", PC, 32'h4);
      check("eor_r1", dut.rf_q[1], 32'h0);
      check("halt_req_cnt", halt_req, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
